// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and event-decodes a raw push button.
//
// Ports:
//   clk100        system clock, all logic on its rising edge
//   rst_n         asynchronous active-low reset
//   button        raw, bouncing, asynchronous button pin (active-high)
//   en            event enable; gates press/release_pulse/hold and the counter only
//   level         debounced button level
//   press         one-cycle pulse on a debounced rising transition
//   release_pulse one-cycle pulse on a debounced falling transition
//   hold          one-cycle pulse once per press after HOLD_CYCLES
//   press_count   number of qualified presses, wrapping modulo 2^CNT_W
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int CNT_W           = 8
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             button,
    input  logic             en,
    output logic             level,
    output logic             press,
    output logic             release_pulse,
    output logic             hold,
    output logic [CNT_W-1:0] press_count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {RELEASED, PRESSING, PRESSED, RELEASING} state_t;

    state_t        state;
    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] h_cnt;
    logic          mismatch, db_done, rise, fall, holding, hold_hit;

    always_comb begin
        mismatch = s2 != level;
        db_done  = mismatch && db_cnt == DB_LAST;
        rise     = state == PRESSING && db_done;
        fall     = state == RELEASING && db_done;
        holding  = state == PRESSED || state == RELEASING;
        // h_cnt saturates at H_MAX, so this matches only on the step that first reaches it
        hold_hit = holding && h_cnt == H_MAX - HW'(1);
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= RELEASED;
            level         <= 1'b0;
            db_cnt        <= '0;
            h_cnt         <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
            press_count   <= '0;
        end else begin
            s1     <= button;
            s2     <= s1;
            // any cycle where s2 agrees with level restarts the stability count
            db_cnt <= (mismatch && !db_done) ? db_cnt + DW'(1) : '0;
            if (db_done)
                level <= s2;
            unique case (state)
                RELEASED:  if (mismatch) state <= PRESSING;
                PRESSING:  state <= !mismatch ? RELEASED : db_done ? PRESSED : PRESSING;
                PRESSED:   if (mismatch) state <= RELEASING;
                RELEASING: state <= !mismatch ? PRESSED : db_done ? RELEASED : RELEASING;
                default:   state <= RELEASED;
            endcase
            // a bounce back from RELEASING keeps the hold progress of the same press
            h_cnt <= rise ? '0 : (holding && h_cnt != H_MAX) ? h_cnt + HW'(1) : h_cnt;
            press         <= en && rise;
            release_pulse <= en && fall;
            hold          <= en && hold_hit;
            if (en && rise)
                press_count <= press_count + CNT_W'(1);
        end
    end
endmodule
